// File: rtl/dev_pkg.sv
// ---------------------------------------------------------------------------
// dev_pkg : shared types, LFSR constants and saturation helper for dev_seq
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dev_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] c_lfsr_mask = 32'h8020_0003;
  localparam logic [31:0] c_lfsr_seed = 32'hACE1_2468;

  // Galois, right-shift form: taps folded in when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? c_lfsr_mask : 32'h0);
  endfunction

  // Clamp a signed value into the two's complement range of w bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (v > max_v) return max_v;
    if (v < min_v) return min_v;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dev_seq_sqrt_iter.sv
// ---------------------------------------------------------------------------
// sqrt_iter : restoring bit-serial square root, one root bit per cycle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sqrt_iter #(
  parameter int WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   radicand,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     root
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] rad_q, rad_d;
  logic [WIDTH+1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   root_q, root_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic [WIDTH+1:0]   w_shifted;
  logic [WIDTH+1:0]   w_trial;
  logic               w_last;

  // Remainder never exceeds 2*partial_root, so its low WIDTH bits are enough
  // before the next pair of radicand bits is brought down.
  assign w_shifted = {rem_q[WIDTH-1:0], rad_q[2*WIDTH-1 -: 2]};
  assign w_trial   = {root_q, 2'b01};
  assign w_last    = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      rad_d  = radicand;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rad_d = {rad_q[2*WIDTH-3:0], 2'b00};
      if (w_shifted >= w_trial) begin
        rem_d  = w_shifted - w_trial;
        root_d = {root_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = w_shifted;
        root_d = {root_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CW'(1);
      if (w_last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q & w_last;
  assign root = root_q;

endmodule

`default_nettype wire

// File: rtl/dev_seq.sv
// ---------------------------------------------------------------------------
// dev_seq : sequential reparameterisation deviate, d_out = floor(sqrt(sp_in)) * eps
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dev_seq
  import dev_pkg::*;
#(
  parameter int          WIDTH     = 20,
  parameter int          FRAC      = 15,
  parameter logic [31:0] LFSR_SEED = c_lfsr_seed
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sp_in,
  input  logic             eps_signed,
  input  logic             seed_load,
  input  logic [31:0]      seed_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] std_out
);

  localparam int PW = WIDTH + FRAC + 2;

  state_e             state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [FRAC:0]      eps_q, eps_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   std_q, std_d;

  logic               w_hs;
  logic [FRAC:0]      w_eps_new;
  logic [2*WIDTH-1:0] w_radicand;
  logic               w_sq_busy;
  logic               w_sq_done;
  logic [WIDTH-1:0]   w_root;
  logic signed [PW-1:0] w_root_x;
  logic signed [PW-1:0] w_eps_x;
  logic signed [PW-1:0] w_prod;

  assign w_hs      = (state_q == IDLE) && in_valid;
  assign w_eps_new = eps_signed ? lfsr_q[FRAC:0] : {1'b0, lfsr_q[FRAC-1:0]};

  // A negative variance yields a zero root but still takes the full iteration count.
  assign w_radicand = sp_in[WIDTH-1] ? '0 : ({{WIDTH{1'b0}}, sp_in} << FRAC);

  sqrt_iter #(
    .WIDTH (WIDTH)
  ) u_sqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_hs & ~w_sq_busy),
    .radicand (w_radicand),
    .busy     (w_sq_busy),
    .done     (w_sq_done),
    .root     (w_root)
  );

  assign w_root_x = $signed({{(FRAC + 2){1'b0}}, w_root});
  assign w_eps_x  = $signed({{(PW - FRAC - 1){eps_q[FRAC]}}, eps_q});
  assign w_prod   = w_root_x * w_eps_x;

  always_comb begin
    state_d = state_q;
    eps_d   = eps_q;
    d_d     = d_q;
    std_d   = std_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          eps_d   = w_eps_new;
          state_d = CALC;
        end
      end
      CALC: begin
        if (w_sq_done) state_d = MUL;
      end
      MUL: begin
        d_d     = WIDTH'(saturate(64'(w_prod >>> FRAC), WIDTH));
        std_d   = w_root;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Seed load wins over a same-cycle step; eps above already saw the old value.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load) begin
      lfsr_d = (seed_val == 32'h0) ? LFSR_SEED : seed_val;
    end else if (w_hs) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      eps_q   <= '0;
      d_q     <= '0;
      std_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      eps_q   <= eps_d;
      d_q     <= d_d;
      std_q   <= std_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d_out     = d_q;
  assign std_out   = std_q;

endmodule

`default_nettype wire

// File: tb/tb_dev_seq.sv
// ---------------------------------------------------------------------------
// tb_dev_seq : directed vector table, corner sequences and random scoreboard for dev_seq
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_dev_seq;

  localparam int          W    = 20;
  localparam int          F    = 15;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  sp_in = '0;
  logic          eps_signed = 1'b0;
  logic          seed_load = 1'b0;
  logic [31:0]   seed_val = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  d_out;
  logic [W-1:0]  std_out;

  always #5 clk = ~clk;

  dev_seq #(
    .WIDTH     (W),
    .FRAC      (F),
    .LFSR_SEED (SEED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sp_in      (sp_in),
    .eps_signed (eps_signed),
    .seed_load  (seed_load),
    .seed_val   (seed_val),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .d_out      (d_out),
    .std_out    (std_out)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_lfsr;

  typedef struct {
    bit          do_seed;
    logic [31:0] seed;
    logic [W-1:0] sp;
    logic        es;
    int          bp;
    logic [W-1:0] xs;
    logic [W-1:0] xd;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] sv);
    return (sv == 32'h0) ? SEED : sv;
  endfunction

  function automatic longint isqrt(input longint r);
    longint lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 21;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= r) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic longint m_std(input logic [W-1:0] sp);
    if (sp[W-1]) return 0;
    return isqrt(longint'(sp) * 32768);
  endfunction

  function automatic longint m_eps(input logic [31:0] l, input logic es);
    longint v;
    if (es) begin
      v = longint'(l[15:0]);
      if (l[15]) v = v - 65536;
    end else begin
      v = longint'(l[14:0]);
    end
    return v;
  endfunction

  function automatic logic [W-1:0] m_d(input longint s, input longint e);
    longint p, q;
    p = s * e;
    q = (p >= 0) ? (p / 32768) : -((-p + 32767) / 32768);
    if (q > 524287) q = 524287;
    if (q < -524288) q = -524288;
    return q[W-1:0];
  endfunction

  // ---------------- stimulus tasks (enter and leave just after a negedge) ----------------
  task automatic do_seed(input logic [31:0] sv);
    seed_load = 1'b1;
    seed_val  = sv;
    @(posedge clk);
    m_lfsr = m_load(sv);
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // slm: 0 no seed load, 1 seed load with the handshake, 2 seed load mid-CALC
  task automatic txn(input logic [W-1:0] sp, input logic es, input int bp, input int slm,
                     input logic [31:0] sv, input logic [W-1:0] xs, input logic [W-1:0] xd);
    int cyc;
    check("idle_in_ready", 64'(in_ready), 64'(1));
    in_valid   = 1'b1;
    sp_in      = sp;
    eps_signed = es;
    if (slm == 1) begin
      seed_load = 1'b1;
      seed_val  = sv;
    end
    @(posedge clk);
    m_lfsr = (slm == 1) ? m_load(sv) : m_step(m_lfsr);
    @(negedge clk);
    in_valid  = 1'b0;
    seed_load = 1'b0;
    sp_in     = $urandom;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (cyc == 10) check("calc_in_ready", 64'(in_ready), 64'(0));
      if (slm == 2 && cyc == 5) begin
        seed_load = 1'b1;
        seed_val  = sv;
      end
      @(posedge clk);
      if (seed_load) m_lfsr = m_load(sv);
      @(negedge clk);
      seed_load = 1'b0;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(22));
    check("std_out", 64'(std_out), 64'(xs));
    check("d_out", 64'(d_out), 64'(xd));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", 64'(out_valid), 64'(1));
      check("hold_in_ready", 64'(in_ready), 64'(0));
      check("hold_std", 64'(std_out), 64'(xs));
      check("hold_d", 64'(d_out), 64'(xd));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", 64'(out_valid), 64'(0));
    check("post_in_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [W-1:0] sp;
    logic         es;
    logic [31:0]  sv;
    int           slm;
    longint       xs;
    bit           stale;

    tbl[0] = '{1'b1, 32'h0000_C000, 20'd32768,  1'b0, 5, 20'd32768,  20'd16384};
    tbl[1] = '{1'b1, 32'h0000_C000, 20'd131072, 1'b1, 0, 20'd65536,  20'hF8000};
    tbl[2] = '{1'b0, 32'h0,         20'd65536,  1'b0, 1, 20'd46340,  20'd34755};
    tbl[3] = '{1'b0, 32'h0,         20'h7FFFF,  1'b0, 0, 20'd131071, 20'd49151};
    tbl[4] = '{1'b0, 32'h0,         20'h80000,  1'b0, 2, 20'd0,      20'd0};
    tbl[5] = '{1'b0, 32'h0,         20'd32768,  1'b1, 0, 20'd32768,  20'd3072};
    tbl[6] = '{1'b1, 32'h0,         20'd32768,  1'b0, 0, 20'd32768,  20'd9320};

    // reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_d_out", 64'(d_out), 64'(0));
    check("rst_std_out", 64'(std_out), 64'(0));
    rst_n  = 1'b1;
    m_lfsr = SEED;
    @(negedge clk);

    // directed vector table
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].do_seed) do_seed(tbl[i].seed);
      txn(tbl[i].sp, tbl[i].es, tbl[i].bp, 0, 32'h0, tbl[i].xs, tbl[i].xd);
    end

    // seed load coincident with handshake: eps from old value, no step afterwards
    do_seed(32'h0000_C000);
    txn(20'd32768, 1'b0, 0, 1, 32'h0000_8000, 20'd32768, 20'd16384);
    txn(20'd32768, 1'b1, 0, 0, 32'h0,         20'd32768, 20'hF8000);
    // seed load while CALC is running
    txn(20'd32768, 1'b0, 0, 2, 32'h0000_1234, 20'd32768, 20'd16384);
    txn(20'd32768, 1'b0, 0, 0, 32'h0,         20'd32768, 20'd4660);

    // reset at cycle 10 of CALC
    in_valid = 1'b1;
    sp_in    = 20'd32768;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_d_out", 64'(d_out), 64'(0));
    check("midrst_std_out", 64'(std_out), 64'(0));
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    m_lfsr = SEED;
    stale  = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    check("no_stale_output", 64'(stale), 64'(0));
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    txn(20'd32768, 1'b0, 0, 0, 32'h0, 20'd32768, 20'd9320);

    // random scoreboard
    for (int n = 0; n < 1000; n++) begin
      sp  = $urandom;
      if ($urandom_range(0, 3) != 0) sp[W-1] = 1'b0;
      es  = 1'($urandom_range(0, 1));
      slm = $urandom_range(0, 9);
      if (slm > 2) slm = 0;
      sv  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 19) == 0) do_seed(($urandom_range(0, 1) == 0) ? 32'h0 : $urandom);
      xs = m_std(sp);
      txn(sp, es, $urandom_range(0, 2), slm, sv, xs[W-1:0], m_d(xs, m_eps(m_lfsr, es)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
